uart_receiver: RTL and testbench

//  8N1 UART receive path for the CPU side of the serial interface; companion of the 8N1 transmit path.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync.sv | 29 ++
 rtl/uart_receiver.sv | 153 +++++++++++++++
 tb/tb_uart_receiver.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// =============================================================================
// Module   : uart_pkg
// Brief    : Shared UART constants and receive-state encoding (RX and TX paths)
// Revision : 1.0 - initial release
// =============================================================================
package uart_pkg;

    localparam int BAUD_CLKS = 260;
    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } uart_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// =============================================================================
// Module   : uart_sync
// Brief    : Flop-chain synchronizer for an asynchronous line; resets to idle (1)
// Revision : 1.0 - initial release
// =============================================================================
module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '1;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// =============================================================================
// Module   : uart_receiver
// Brief    : 8N1 UART receiver with one-entry valid/ready holding register,
//            framing-error and overrun pulses. Optional RTS via UART_RX_RTS_EN.
// Revision : 1.0 - initial release
// =============================================================================
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = BAUD_CLKS,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pin_rx,
`ifdef UART_RX_RTS_EN
    output logic                 pin_rts,
`endif
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W = $clog2(DATA_BITS);
    localparam logic [c_CNT_W-1:0] c_HALF     = c_CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [c_CNT_W-1:0] c_LAST     = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_BITS - 1);

    logic                 w_rxs;
    uart_rx_state_t       r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    uart_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (pin_rx),
        .o_sync  (w_rxs)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!w_rxs) begin
                        r_state <= START;
                    end
                end
                START: begin
                    // Mid-start-bit check rejects glitches shorter than half a bit
                    if (r_cnt == c_HALF) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= w_rxs ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == c_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
                        if (r_idx == c_IDX_LAST) begin
                            r_state <= STOP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt == c_LAST) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            r_state <= IDLE;
                            // A slot is free if empty or being drained this cycle
                            if (!r_rx_valid || rx_ready) begin
                                r_rx_data  <= r_shift;
                                r_rx_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= WAIT_HI;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_HI: begin
                    r_cnt <= '0;
                    if (w_rxs) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

`ifdef UART_RX_RTS_EN
    logic r_rts;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rts <= 1'b0;
        end else begin
            r_rts <= r_rx_valid && !rx_ready;
        end
    end

    assign pin_rts = r_rts;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// =============================================================================
// Module   : tb_uart_receiver
// Brief    : Directed self-checking bench for uart_receiver (8N1, 260 clk/bit)
// Revision : 1.0 - initial release
// =============================================================================
module tb_uart_receiver;

    localparam int c_BIT = 260;

    logic       clk = 1'b0;
    logic       rst;
    logic       pin_rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_RTS_EN
    logic       pin_rts;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_start = 0;

    int         n_acc = 0;
    logic [7:0] last_acc = '0;
    int         n_ferr = 0;
    int         n_ovr = 0;
    int         n_vcyc = 0;
    int         rise_cyc = 0;
    logic       prev_valid = 1'b0;

    uart_receiver #(
        .CLKS_PER_BIT (c_BIT),
        .SYNC_STAGES  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pin_rx    (pin_rx),
`ifdef UART_RX_RTS_EN
        .pin_rts   (pin_rts),
`endif
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            n_acc    <= n_acc + 1;
            last_acc <= rx_data;
        end
        if (frame_err) n_ferr <= n_ferr + 1;
        if (overrun)   n_ovr  <= n_ovr + 1;
        if (rx_valid)  n_vcyc <= n_vcyc + 1;
        if (rx_valid && !prev_valid) rise_cyc <= cyc;
        prev_valid <= rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int period);
        pin_rx  = 1'b0;
        t_start = cyc;
        tick(period);
        for (int i = 0; i < 8; i++) begin
            pin_rx = b[i];
            tick(period);
        end
        pin_rx = stop_bit;
        tick(period);
    endtask

    initial begin
        int a;
        int f;
        int o;
        int v;

        rst      = 1'b1;
        pin_rx   = 1'b1;
        rx_ready = 1'b1;
        tick(5);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
`ifdef UART_RX_RTS_EN
        chk("rst_rts", 32'(pin_rts), 32'd0);
`endif
        rst = 1'b0;
        tick(10);

        // 1: clean frame, exact latency from start edge to rx_valid
        a = n_acc; v = n_vcyc;
        send_byte(8'hA5, 1'b1, c_BIT);
        tick(20);
        chk("t1_count", 32'(n_acc - a), 32'd1);
        chk("t1_data", 32'(last_acc), 32'hA5);
        chk("t1_valid_cycles", 32'(n_vcyc - v), 32'd1);
        chk("t1_latency", 32'(rise_cyc - t_start), 32'd2474);
        chk("t1_ferr", 32'(n_ferr), 32'd0);
        chk("t1_ovr", 32'(n_ovr), 32'd0);

        // 2: short low glitch is rejected
        a = n_acc;
        pin_rx = 1'b0;
        tick(50);
        pin_rx = 1'b1;
        tick(400);
        chk("t2_glitch_count", 32'(n_acc - a), 32'd0);
        chk("t2_glitch_ferr", 32'(n_ferr), 32'd0);
        send_byte(8'h3C, 1'b1, c_BIT);
        tick(20);
        chk("t2_count", 32'(n_acc - a), 32'd1);
        chk("t2_data", 32'(last_acc), 32'h3C);

        // 3: bad stop bit followed by a break
        a = n_acc; f = n_ferr;
        send_byte(8'h3C, 1'b0, c_BIT);
        tick(5 * c_BIT);
        pin_rx = 1'b1;
        tick(600);
        chk("t3_ferr", 32'(n_ferr - f), 32'd1);
        chk("t3_count", 32'(n_acc - a), 32'd0);
        send_byte(8'h96, 1'b1, c_BIT);
        tick(20);
        chk("t3_next_count", 32'(n_acc - a), 32'd1);
        chk("t3_next_data", 32'(last_acc), 32'h96);

        // 4: overrun while the holding register is full
        rx_ready = 1'b0;
        a = n_acc; o = n_ovr;
        send_byte(8'h11, 1'b1, c_BIT);
        tick(20);
        send_byte(8'h22, 1'b1, c_BIT);
        tick(20);
        chk("t4_valid", 32'(rx_valid), 32'd1);
        chk("t4_data", 32'(rx_data), 32'h11);
        chk("t4_ovr", 32'(n_ovr - o), 32'd1);
        chk("t4_ferr", 32'(n_ferr - f), 32'd1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(5);
        chk("t4_drained", 32'(rx_valid), 32'd0);
        chk("t4_data_kept", 32'(rx_data), 32'h11);
        chk("t4_acc_count", 32'(n_acc - a), 32'd1);
        chk("t4_acc_data", 32'(last_acc), 32'h11);
        rx_ready = 1'b1;
        tick(10);

        // 5: reset in the middle of a frame
        a = n_acc; f = n_ferr;
        pin_rx = 1'b0;
        tick(c_BIT);
        for (int i = 0; i < 4; i++) begin
            pin_rx = 1'b1;
            tick(c_BIT);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t5_valid_after_rst", 32'(rx_valid), 32'd0);
        tick(5 * c_BIT);
        chk("t5_count", 32'(n_acc - a), 32'd0);
        chk("t5_ferr", 32'(n_ferr - f), 32'd0);
        send_byte(8'h7E, 1'b1, c_BIT);
        tick(20);
        chk("t5_next_count", 32'(n_acc - a), 32'd1);
        chk("t5_next_data", 32'(last_acc), 32'h7E);

`ifdef UART_RX_RTS_EN
        // 6: RTS follows the holding register with one cycle of lag
        begin
            bit found;
            found    = 1'b0;
            rx_ready = 1'b0;
            pin_rx   = 1'b0;
            tick(c_BIT);
            for (int i = 0; i < 8; i++) begin
                pin_rx = 1'(8'h55 >> i);
                tick(c_BIT);
            end
            pin_rx = 1'b1;
            for (int i = 0; i < 2 * c_BIT && !found; i++) begin
                @(negedge clk);
                if (rx_valid) found = 1'b1;
            end
            chk("t6_valid_seen", 32'(found), 32'd1);
            chk("t6_rts_at_valid", 32'(pin_rts), 32'd0);
            @(negedge clk);
            chk("t6_rts_raised", 32'(pin_rts), 32'd1);
            @(posedge clk);
            #1;
            rx_ready = 1'b1;
            @(negedge clk);
            chk("t6_rts_handshake", 32'(pin_rts), 32'd1);
            chk("t6_data", 32'(rx_data), 32'h55);
            @(posedge clk);
            #1;
            rx_ready = 1'b0;
            @(negedge clk);
            chk("t6_rts_fall", 32'(pin_rts), 32'd0);
            tick(c_BIT);
            rx_ready = 1'b1;
        end
`endif

        // Baud tolerance at both ends of the window
        a = n_acc;
        send_byte(8'hA5, 1'b1, 255);
        tick(20);
        chk("baud255_data", 32'(last_acc), 32'hA5);
        send_byte(8'hA5, 1'b1, 265);
        tick(20);
        chk("baud265_data", 32'(last_acc), 32'hA5);
        chk("baud_count", 32'(n_acc - a), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
